bf16_add_out: RTL and testbench
===============================

# bf16_add_out

Output stage for the bfloat16 adder. Registers the raw combinational sum from `bf16_add`, overrides it with IEEE special-case results (NaN, infinity, signed zero, subnormal flush, overflow), and presents it on a valid/ready stream through a 2-entry skid buffer. It also keeps sticky exception flags. It sits directly downstream of `bf16_add` and receives both the original operands and the adder's result on the same beat.

## Interface
- `E`, default 8: exponent width, fixed localparam.
- `M`, default 7: mantissa width, fixed localparam.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `in_valid_i`  in  1  beat valid (operands plus adder result).
- `in_ready_o`  out  1  stage can accept a beat.
- `sa_i`, `ea_i`, `ma_i`  in  1/E/M  operand a, original fields.
- `sb_i`, `eb_i`, `mb_i`  in  1/E/M  operand b, original fields.
- `sr_i`, `er_i`, `mr_i`  in  1/E/M  raw `bf16_add` result for this beat.
- `out_valid_o`  out  1  result valid.
- `out_ready_i`  in  1  consumer accepts result.
- `s_o`, `e_o`, `m_o`  out  1/E/M  final result.
- `clr_flags_i`  in  1  clear sticky flags.
- `flag_nv_o`, `flag_of_o`, `flag_uf_o`  out  1 each  sticky invalid / overflow / underflow.

## Operation
- Operand classes (per operand x):
  - NaN: e=FF, m≠0.
  - Inf: e=FF, m=0.
  - Zero: e=00; subnormals are flushed to zero and keep their sign.
  - Otherwise finite.
- Result select, in priority order:
  1. Either operand NaN, or Inf+Inf with opposite signs → canonical NaN {0, FF, 40}; raises nv.
  2. Either operand Inf → that Inf, with its sign.
  3. Both operands zero → zero with sign = sa & sb.
  4. Exactly one operand zero → the other operand, bit-exact (raw adder result ignored).
  5. Both finite:
     - er_i = FF → Inf with sign sr_i; raises of.
     - er_i = 00 and mr_i = 0 (exact cancellation) → +0; raises no flag.
     - er_i = 00 and mr_i ≠ 0 → zero with sign sr_i (flush); raises uf.
     - else → {sr_i, er_i, mr_i} unchanged.
- Selection is combinational on the input beat. The selected result is what gets stored in the buffer.
- Skid buffer: a main register (drives the outputs) and a skid register.
  - `in_ready_o` is registered and equals "skid register empty".
  - Accepted beat (in_valid_i & in_ready_o): goes to main if main is empty or is being consumed this cycle; otherwise goes to skid.
  - Main consumed (out_valid_o & out_ready_i) while skid is full: skid moves to main and skid empties.
  - Simultaneous accept and consume with skid full cannot happen, because in_ready_o=0 in that case.
- Flags:
  - Set on the cycle the causing beat is accepted, not when it is delivered.
  - `clr_flags_i` has priority over a set in the same cycle.
- Reset mid-stream discards both buffered beats; no output handshake completes for them.

## Timing
- Latency: 1 cycle. A beat accepted at edge n is visible on the outputs after edge n with out_valid_o=1, provided main was empty or being drained.
- Throughput: 1 beat/cycle with out_ready_i held high.
- After a single stall cycle, in_ready_o drops on the next cycle. It rises the cycle after the skid register drains.
- Outputs are held stable while out_valid_o=1 and out_ready_i=0.
- Reset values:
  - out_valid_o=0, in_ready_o=1.
  - s_o/e_o/m_o = 0.
  - All flags = 0; skid register empty.

## Configuration
- `BF16_ADD_OUT_FLAGS_EN`:
  - Defined: sticky flag registers and `clr_flags_i` logic are compiled in, as described above.
  - Undefined: no flag registers exist; flag_nv_o/flag_of_o/flag_uf_o are tied to 0 and clr_flags_i is ignored. Datapath and handshake are identical in both builds.

## Test plan
- NaN and Inf select.
  - a=7FC1, b=3F80, result inputs arbitrary → out 7FC0 after 1 cycle; flag_nv_o=1.
  - Clr_flags_i pulse → flag_nv_o=0 on the next cycle.
- Inf cases.
  - a=7F80, b=FF80 → 7FC0, nv=1.
  - a=FF80, b=3F80 → FF80, nv=0.
- Zero cases.
  - a=8000, b=8000 → 8000.
  - a=8000, b=0000 → 0000.
  - a=0001 (subnormal), b=C040 → C040.
  - Both finite, raw result er=00, mr=00 → 0000 with no flag.
  - Raw result er=00, mr=05, sr=1 → 8000 with uf=1.
- Overflow: a=7F7F, b=7F7F, raw result {0, FF, 00} → 7F80, flag_of_o=1.
- Backpressure: stream beats 1..4 with out_ready_i low for cycles 2–3.
  - in_ready_o=0 while the skid register holds beat 2.
  - Outputs are delivered in order 1,2,3,4 with no loss or duplication.
  - Full throughput resumes once out_ready_i is high.
- Reset mid-stream: assert rst with both registers full → next cycle out_valid_o=0, in_ready_o=1, flags 0. Build with `BF16_ADD_OUT_FLAGS_EN` undefined → flags stay 0 through the NaN test.

Source files
------------

// File: rtl/bf16_add_out.sv
// rtl/bf16_add_out.sv - bf16 adder output stage: special-case select, 2-entry skid buffer, sticky flags
// Optional macro BF16_ADD_OUT_FLAGS_EN compiles in the sticky flag registers.
module bf16_add_out #(
    localparam int E = 8,
    localparam int M = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic         sa_i,
    input  logic [E-1:0] ea_i,
    input  logic [M-1:0] ma_i,
    input  logic         sb_i,
    input  logic [E-1:0] eb_i,
    input  logic [M-1:0] mb_i,
    input  logic         sr_i,
    input  logic [E-1:0] er_i,
    input  logic [M-1:0] mr_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic         s_o,
    output logic [E-1:0] e_o,
    output logic [M-1:0] m_o,
    input  logic         clr_flags_i,
    output logic         flag_nv_o,
    output logic         flag_of_o,
    output logic         flag_uf_o
);
    localparam int W = 1 + E + M;
    localparam logic [E-1:0] EMAX = '1;
    localparam logic [W-1:0] QNAN = {1'b0, EMAX, 1'b1, {(M-1){1'b0}}};

    logic         w_a_nan, w_a_inf, w_a_zero;
    logic         w_b_nan, w_b_inf, w_b_zero;
    logic [W-1:0] w_sel;
    logic         w_nv, w_of, w_uf;
    logic         w_accept, w_consume;

    logic         r_main_valid, r_skid_valid;
    logic [W-1:0] r_main, r_skid;

    assign w_a_nan  = (ea_i == EMAX) && (ma_i != '0);
    assign w_a_inf  = (ea_i == EMAX) && (ma_i == '0);
    assign w_a_zero = (ea_i == '0);
    assign w_b_nan  = (eb_i == EMAX) && (mb_i != '0);
    assign w_b_inf  = (eb_i == EMAX) && (mb_i == '0);
    assign w_b_zero = (eb_i == '0);

    always_comb begin
        w_sel = {sr_i, er_i, mr_i};
        w_nv  = 1'b0;
        w_of  = 1'b0;
        w_uf  = 1'b0;
        if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (sa_i != sb_i))) begin
            w_sel = QNAN;
            w_nv  = 1'b1;
        end else if (w_a_inf) begin
            w_sel = {sa_i, ea_i, ma_i};
        end else if (w_b_inf) begin
            w_sel = {sb_i, eb_i, mb_i};
        end else if (w_a_zero && w_b_zero) begin
            w_sel = {sa_i & sb_i, {(E+M){1'b0}}};
        end else if (w_a_zero) begin
            w_sel = {sb_i, eb_i, mb_i};
        end else if (w_b_zero) begin
            w_sel = {sa_i, ea_i, ma_i};
        end else if (er_i == EMAX) begin
            w_sel = {sr_i, EMAX, {M{1'b0}}};
            w_of  = 1'b1;
        end else if (er_i == '0) begin
            // exact cancellation gives +0 silently; a tiny nonzero result is flushed
            w_sel = (mr_i == '0) ? '0 : {sr_i, {(E+M){1'b0}}};
            w_uf  = (mr_i != '0);
        end
    end

    assign w_accept  = in_valid_i && !r_skid_valid;
    assign w_consume = r_main_valid && out_ready_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_main       <= '0;
            r_skid       <= '0;
        end else if (w_accept) begin
            if (!r_main_valid || w_consume) begin
                r_main       <= w_sel;
                r_main_valid <= 1'b1;
            end else begin
                r_skid       <= w_sel;
                r_skid_valid <= 1'b1;
            end
        end else if (w_consume) begin
            if (r_skid_valid) begin
                r_main       <= r_skid;
                r_skid_valid <= 1'b0;
            end else begin
                r_main_valid <= 1'b0;
            end
        end
    end

    assign in_ready_o          = !r_skid_valid;
    assign out_valid_o         = r_main_valid;
    assign {s_o, e_o, m_o}     = r_main;

`ifdef BF16_ADD_OUT_FLAGS_EN
    logic r_flag_nv, r_flag_of, r_flag_uf;

    always_ff @(posedge clk) begin
        if (rst || clr_flags_i) begin
            r_flag_nv <= 1'b0;
            r_flag_of <= 1'b0;
            r_flag_uf <= 1'b0;
        end else if (w_accept) begin
            r_flag_nv <= r_flag_nv | w_nv;
            r_flag_of <= r_flag_of | w_of;
            r_flag_uf <= r_flag_uf | w_uf;
        end
    end

    assign flag_nv_o = r_flag_nv;
    assign flag_of_o = r_flag_of;
    assign flag_uf_o = r_flag_uf;
`else
    logic w_unused_flags;
    assign w_unused_flags = ^{clr_flags_i, w_nv, w_of, w_uf};
    assign flag_nv_o = 1'b0;
    assign flag_of_o = 1'b0;
    assign flag_uf_o = 1'b0;
`endif
endmodule

// File: tb/tb_bf16_add_out.sv
// tb/tb_bf16_add_out.sv - self-checking bench for bf16_add_out with a queue-based reference model
module tb_bf16_add_out;
`ifdef BF16_ADD_OUT_FLAGS_EN
    localparam bit FL = 1'b1;
`else
    localparam bit FL = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid_i = 1'b0;
    logic        out_ready_i = 1'b0;
    logic        clr_flags_i = 1'b0;
    logic [15:0] a = '0, b = '0, r = '0;
    logic        in_ready_o, out_valid_o, s_o;
    logic [7:0]  e_o;
    logic [6:0]  m_o;
    logic        flag_nv_o, flag_of_o, flag_uf_o;

    always #5 clk = ~clk;

    bf16_add_out dut (
        .clk(clk), .rst(rst),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .sa_i(a[15]), .ea_i(a[14:7]), .ma_i(a[6:0]),
        .sb_i(b[15]), .eb_i(b[14:7]), .mb_i(b[6:0]),
        .sr_i(r[15]), .er_i(r[14:7]), .mr_i(r[6:0]),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .s_o(s_o), .e_o(e_o), .m_o(m_o),
        .clr_flags_i(clr_flags_i),
        .flag_nv_o(flag_nv_o), .flag_of_o(flag_of_o), .flag_uf_o(flag_uf_o)
    );

    int          checks = 0;
    int          failures = 0;
    logic [15:0] q[$];
    logic [15:0] delivered[$];
    logic [2:0]  mflags = '0;
    bit          armed = 1'b0;
    bit          last_acc = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // {result, nv, of, uf} straight from the operand-class rules
    function automatic logic [18:0] ref_sel(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
        bit xn, yn, xi, yi, xz, yz;
        xn = (x[14:7] == 8'hFF) && (x[6:0] != 0);
        yn = (y[14:7] == 8'hFF) && (y[6:0] != 0);
        xi = (x[14:7] == 8'hFF) && (x[6:0] == 0);
        yi = (y[14:7] == 8'hFF) && (y[6:0] == 0);
        xz = (x[14:7] == 8'h00);
        yz = (y[14:7] == 8'h00);
        if (xn || yn || (xi && yi && x[15] != y[15])) return {16'h7FC0, 3'b100};
        if (xi) return {x, 3'b000};
        if (yi) return {y, 3'b000};
        if (xz && yz) return {x[15] & y[15], 15'h0, 3'b000};
        if (xz) return {y, 3'b000};
        if (yz) return {x, 3'b000};
        if (z[14:7] == 8'hFF) return {z[15], 15'h7F80, 3'b010};
        if (z[14:7] == 8'h00) return (z[6:0] == 0) ? 19'h0 : {z[15], 15'h0, 3'b001};
        return {z, 3'b000};
    endfunction

    function automatic logic [15:0] rnd16();
        logic [7:0] ex;
        logic [6:0] mn;
        case ($urandom_range(0, 5))
            0:       ex = 8'h00;
            1:       ex = 8'hFF;
            default: ex = 8'($urandom);
        endcase
        mn = ($urandom_range(0, 3) == 0) ? 7'h0 : 7'($urandom);
        return {1'($urandom), ex, mn};
    endfunction

    // one clock edge: model absorbs the pre-edge inputs, then inputs may change
    task automatic step();
        bit acc, con;
        logic [18:0] s;
        @(posedge clk);
        acc = in_valid_i && (q.size() < 2);
        con = (q.size() > 0) && out_ready_i;
        s   = ref_sel(a, b, r);
        last_acc = 1'b0;
        if (rst) begin
            q.delete();
            mflags = '0;
            armed  = 1'b1;
        end else begin
            if (con) delivered.push_back(q.pop_front());
            if (acc) q.push_back(s[18:3]);
            last_acc = acc;
            if (clr_flags_i) mflags = '0;
            else if (acc) mflags = mflags | s[2:0];
        end
        #1;
    endtask

    always @(negedge clk) begin
        if (armed) begin
            chk("out_valid", 32'(out_valid_o), 32'(q.size() > 0));
            chk("in_ready", 32'(in_ready_o), 32'(q.size() < 2));
            if (q.size() > 0) chk("data", 32'({s_o, e_o, m_o}), 32'(q[0]));
            chk("flags", 32'({flag_nv_o, flag_of_o, flag_uf_o}), 32'(FL ? mflags : 3'b000));
        end
    end

    task automatic beat(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
        a = x; b = y; r = z;
        in_valid_i = 1'b1; out_ready_i = 1'b1;
        step();
        in_valid_i = 1'b0;
    endtask

    task automatic lit(input string name, input logic [15:0] exp, input logic [2:0] fl);
        @(negedge clk);
        chk({name, "_out"}, 32'({s_o, e_o, m_o}), 32'(exp));
        chk({name, "_flags"}, 32'({flag_nv_o, flag_of_o, flag_uf_o}), 32'(FL ? fl : 3'b000));
    endtask

    task automatic clear();
        clr_flags_i = 1'b1;
        step();
        clr_flags_i = 1'b0;
    endtask

    initial begin
        logic [15:0] seq[4];
        int          idx;
        seq[0] = 16'h3F80; seq[1] = 16'h4000; seq[2] = 16'h4040; seq[3] = 16'h4080;

        step(); step();
        rst = 1'b0;
        @(negedge clk);
        chk("reset_out", 32'({s_o, e_o, m_o}), 32'h0);
        chk("reset_ready", 32'({out_valid_o, in_ready_o}), 32'b01);

        beat(16'h7FC1, 16'h3F80, 16'h1234); lit("nan_in", 16'h7FC0, 3'b100);
        clear(); @(negedge clk);
        chk("clr_nv", 32'(flag_nv_o), 32'h0);
        beat(16'h7F80, 16'hFF80, 16'h0000); lit("inf_opp", 16'h7FC0, 3'b100);
        clear();
        beat(16'hFF80, 16'h3F80, 16'h5555); lit("inf_a", 16'hFF80, 3'b000);
        beat(16'h8000, 16'h8000, 16'h1111); lit("zz_neg", 16'h8000, 3'b000);
        beat(16'h8000, 16'h0000, 16'h1111); lit("zz_mix", 16'h0000, 3'b000);
        beat(16'h0001, 16'hC040, 16'h2222); lit("sub_flush", 16'hC040, 3'b000);
        beat(16'h3F80, 16'hBF80, 16'h0000); lit("cancel", 16'h0000, 3'b000);
        beat(16'h3F80, 16'hBF81, 16'h8005); lit("uflow", 16'h8000, 3'b001);
        clear();
        beat(16'h7F7F, 16'h7F7F, 16'h7F80); lit("oflow", 16'h7F80, 3'b010);
        clear(); step();

        // backpressure: out_ready low across the second and third cycles
        delivered.delete();
        idx = 0;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            out_ready_i = !(cyc == 2 || cyc == 3);
            in_valid_i  = (idx < 4);
            a = 16'h3F80; b = 16'h3F80; r = (idx < 4) ? seq[idx] : 16'h0;
            step();
            if (last_acc) idx++;
            if (cyc == 2) begin
                @(negedge clk);
                chk("skid_stall_ready", 32'(in_ready_o), 32'h0);
            end
        end
        in_valid_i = 1'b0;
        chk("bp_count", 32'(delivered.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            if (i < delivered.size()) chk("bp_order", 32'(delivered[i]), 32'(seq[i]));

        // reset with both registers full and a flag raised
        out_ready_i = 1'b0;
        beat(16'h7FC1, 16'h3F80, 16'h0); out_ready_i = 1'b0;
        in_valid_i = 1'b1; a = 16'h3F80; b = 16'h3F80; r = 16'h4000;
        step(); in_valid_i = 1'b0;
        @(negedge clk);
        chk("full_ready", 32'(in_ready_o), 32'h0);
        rst = 1'b1; step(); rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_valid", 32'({out_valid_o, in_ready_o}), 32'b01);
        chk("rst_mid_flags", 32'({flag_nv_o, flag_of_o, flag_uf_o}), 32'h0);

        // full throughput with out_ready held high
        out_ready_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_valid_i = 1'b1; a = rnd16(); b = rnd16(); r = rnd16();
            step();
            chk("throughput_acc", 32'(last_acc), 32'h1);
        end

        for (int i = 0; i < 3000; i++) begin
            in_valid_i  = ($urandom_range(0, 3) != 0);
            out_ready_i = ($urandom_range(0, 9) < 7);
            clr_flags_i = ($urandom_range(0, 31) == 0);
            a = rnd16(); b = rnd16(); r = rnd16();
            step();
        end
        in_valid_i = 1'b0; clr_flags_i = 1'b0; out_ready_i = 1'b1;
        step(); step(); step();
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
